// File: rtl/chip_test_pkg.sv
// Shared types and constants for the chip-tester run sequencer.
package chip_test_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LAUNCH  = 3'd1,
    WAIT    = 3'd2,
    CAPTURE = 3'd3,
    SHOW    = 3'd4,
    FAULT   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } verdict_t;

  localparam int SEQ_TIMEOUT_DEFAULT = 50000;

  function automatic logic is_busy(input seq_state_t s);
    return (s == LAUNCH) || (s == WAIT) || (s == CAPTURE);
  endfunction

endpackage

// File: rtl/rise_edge_detect.sv
// Rising-edge detector; the history register resets to 1 so a level held through reset is not an edge.
module rise_edge_detect (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk) begin
    if (!reset_n) din_q <= 1'b1;
    else          din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/chip_test_sequencer.sv
// Launches one chip-tester run, waits for Done with a timeout, and holds the verdict until acknowledged.
// Optional SEQ_TALLY_EN compiles in the saturating pass/fail tally counters.
module chip_test_sequencer
  import chip_test_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = SEQ_TIMEOUT_DEFAULT,
  parameter int CNT_W          = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             Ack,
  input  logic             Done,
  input  logic             RSLT,
  output logic             Run,
  output logic             DISP_RSLT,
  output logic             Busy,
  output logic             Pass,
  output logic             Fail,
  output logic             Timeout,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic        start_edge;
  logic        ack_edge;
  seq_state_t  state_reg, state_next;
  verdict_t    verdict_reg, verdict_next;
  logic [15:0] to_cnt_reg;
  logic        run_reg;
  logic        disp_reg;

  rise_edge_detect u_start_edge (
    .clk     (Clk),
    .reset_n (Reset_n),
    .din     (Start),
    .rise    (start_edge)
  );

  rise_edge_detect u_ack_edge (
    .clk     (Clk),
    .reset_n (Reset_n),
    .din     (Ack),
    .rise    (ack_edge)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_edge) state_next = LAUNCH;
      LAUNCH:  state_next = WAIT;
      WAIT: begin
        if (Done)                         state_next = CAPTURE;
        else if (to_cnt_reg == TO_LAST)   state_next = FAULT;
      end
      CAPTURE: state_next = SHOW;
      SHOW, FAULT: begin
        if (start_edge)    state_next = LAUNCH;
        else if (ack_edge) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RSLT lags Done by one cycle, so the verdict is taken from CAPTURE, not WAIT.
  always_comb begin
    verdict_next = verdict_reg;
    if (state_next == LAUNCH)
      verdict_next = NONE;
    else if (state_reg == CAPTURE)
      verdict_next = RSLT ? PASS : FAIL;
    else if (state_reg == WAIT && state_next == FAULT)
      verdict_next = TIMEOUT;
    else if (state_next == IDLE)
      verdict_next = NONE;
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg   <= IDLE;
      verdict_reg <= NONE;
      to_cnt_reg  <= '0;
      run_reg     <= 1'b0;
      disp_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      verdict_reg <= verdict_next;
      run_reg     <= (state_next == LAUNCH);
      // Leaving WAIT lands in CAPTURE or FAULT; both release the tester once.
      disp_reg    <= (state_reg == WAIT) && (state_next != WAIT);
      if (state_reg == LAUNCH)
        to_cnt_reg <= '0;
      else if (state_reg == WAIT)
        to_cnt_reg <= to_cnt_reg + 16'd1;
    end
  end

  assign Run       = run_reg;
  assign DISP_RSLT = disp_reg;
  assign Busy      = is_busy(state_reg);
  assign Pass      = (verdict_reg == PASS);
  assign Fail      = (verdict_reg == FAIL);
  assign Timeout   = (verdict_reg == TIMEOUT);

`ifdef SEQ_TALLY_EN
  logic [CNT_W-1:0] pass_cnt_reg;
  logic [CNT_W-1:0] fail_cnt_reg;

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      pass_cnt_reg <= '0;
      fail_cnt_reg <= '0;
    end else if (state_reg == CAPTURE) begin
      if (RSLT) begin
        if (pass_cnt_reg != '1) pass_cnt_reg <= pass_cnt_reg + 1'b1;
      end else begin
        if (fail_cnt_reg != '1) fail_cnt_reg <= fail_cnt_reg + 1'b1;
      end
    end
  end

  assign pass_count = pass_cnt_reg;
  assign fail_count = fail_cnt_reg;
`else
  assign pass_count = '0;
  assign fail_count = '0;
`endif

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Directed bench for chip_test_sequencer with TIMEOUT_CYCLES=8 and CNT_W=2.
module tb_chip_test_sequencer;

`ifdef SEQ_TALLY_EN
  localparam bit TALLY_ON = 1'b1;
`else
  localparam bit TALLY_ON = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Start = 1'b0;
  logic       Ack = 1'b0;
  logic       Done = 1'b0;
  logic       RSLT = 1'b0;
  logic       Run, DISP_RSLT, Busy, Pass, Fail, Timeout;
  logic [1:0] pass_count, fail_count;

  int vectors = 0;
  int miscompares = 0;

  chip_test_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(2)) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .Start      (Start),
    .Ack        (Ack),
    .Done       (Done),
    .RSLT       (RSLT),
    .Run        (Run),
    .DISP_RSLT  (DISP_RSLT),
    .Busy       (Busy),
    .Pass       (Pass),
    .Fail       (Fail),
    .Timeout    (Timeout),
    .pass_count (pass_count),
    .fail_count (fail_count)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // Stimulus only: one passing run, tester raises Done three cycles after Run.
  task automatic do_pass_run();
    Start = 1'b1; step();
    Start = 1'b0; step(); step(); step();
    Done = 1'b1; RSLT = 1'b1; step();
    Done = 1'b0; step();
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Start = 1'b1; Ack = 1'b1;
    step(); step();
    vectors++;
    if ({Run, DISP_RSLT, Busy, Pass, Fail, Timeout} !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_outputs got=%b want=000000", {Run, DISP_RSLT, Busy, Pass, Fail, Timeout});
    end
    vectors++;
    if ({pass_count, fail_count} !== 4'b0) begin
      miscompares++;
      $display("FAIL reset_counts got=%b want=0000", {pass_count, fail_count});
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      vectors++;
      if ({Run, Busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL held_start_no_run cycle=%0d got={Run,Busy}=%b want=00", i, {Run, Busy});
      end
    end
    Start = 1'b0; Ack = 1'b0; step();
    $display("test_reset done");
  endtask

  task automatic test_pass();
    logic [1:0] exp_p;
    exp_p = TALLY_ON ? 2'd1 : 2'd0;
    Start = 1'b1; step();
    vectors++;
    if ({Run, Busy, Pass} !== 3'b110) begin
      miscompares++;
      $display("FAIL pass_launch got={Run,Busy,Pass}=%b want=110", {Run, Busy, Pass});
    end
    Start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      vectors++;
      if ({Run, Busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL pass_wait cycle=%0d got={Run,Busy}=%b want=01", i, {Run, Busy});
      end
    end
    step();
    Done = 1'b1; RSLT = 1'b1; step();
    vectors++;
    if ({DISP_RSLT, Busy, Pass} !== 3'b110) begin
      miscompares++;
      $display("FAIL pass_capture got={DISP,Busy,Pass}=%b want=110", {DISP_RSLT, Busy, Pass});
    end
    Done = 1'b0; step();
    vectors++;
    if ({DISP_RSLT, Busy, Pass, Fail, Timeout} !== 5'b00100) begin
      miscompares++;
      $display("FAIL pass_show got={DISP,Busy,Pass,Fail,Timeout}=%b want=00100",
               {DISP_RSLT, Busy, Pass, Fail, Timeout});
    end
    vectors++;
    if (pass_count !== exp_p) begin
      miscompares++;
      $display("FAIL pass_count got=%0d want=%0d", pass_count, exp_p);
    end
    $display("test_pass done pass_count=%0d", pass_count);
  endtask

  task automatic test_fail_ack();
    logic [1:0] exp_f;
    exp_f = TALLY_ON ? 2'd1 : 2'd0;
    Start = 1'b1; step();
    vectors++;
    if ({Run, Pass} !== 2'b10) begin
      miscompares++;
      $display("FAIL retest_clears_pass got={Run,Pass}=%b want=10", {Run, Pass});
    end
    Start = 1'b0; step(); step(); step();
    Done = 1'b1; RSLT = 1'b0; step();
    Done = 1'b0; step();
    vectors++;
    if ({Pass, Fail, Timeout, Busy} !== 4'b0100) begin
      miscompares++;
      $display("FAIL fail_show got={Pass,Fail,Timeout,Busy}=%b want=0100", {Pass, Fail, Timeout, Busy});
    end
    vectors++;
    if (fail_count !== exp_f) begin
      miscompares++;
      $display("FAIL fail_count got=%0d want=%0d", fail_count, exp_f);
    end
    Ack = 1'b1; step();
    vectors++;
    if ({Fail, Busy, Run} !== 3'b000) begin
      miscompares++;
      $display("FAIL ack_to_idle got={Fail,Busy,Run}=%b want=000", {Fail, Busy, Run});
    end
    Ack = 1'b0; step();
    $display("test_fail_ack done fail_count=%0d", fail_count);
  endtask

  task automatic test_timeout();
    logic [3:0] exp_cnts;
    exp_cnts = TALLY_ON ? 4'b0101 : 4'b0000;
    Start = 1'b1; step();
    Start = 1'b0; step();
    for (int i = 1; i < 8; i++) begin
      step();
      vectors++;
      if ({Timeout, Busy} !== 2'b01) begin
        miscompares++;
        $display("FAIL timeout_early offset=%0d got={Timeout,Busy}=%b want=01", i, {Timeout, Busy});
      end
    end
    step();
    vectors++;
    if ({Timeout, DISP_RSLT, Busy, Pass, Fail} !== 5'b11000) begin
      miscompares++;
      $display("FAIL timeout_entry got={Timeout,DISP,Busy,Pass,Fail}=%b want=11000",
               {Timeout, DISP_RSLT, Busy, Pass, Fail});
    end
    step();
    vectors++;
    if ({Timeout, DISP_RSLT} !== 2'b10) begin
      miscompares++;
      $display("FAIL timeout_hold got={Timeout,DISP}=%b want=10", {Timeout, DISP_RSLT});
    end
    vectors++;
    if ({pass_count, fail_count} !== exp_cnts) begin
      miscompares++;
      $display("FAIL timeout_counts got=%b want=%b", {pass_count, fail_count}, exp_cnts);
    end
    Ack = 1'b1; step();
    vectors++;
    if ({Timeout, Busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL timeout_ack got={Timeout,Busy}=%b want=00", {Timeout, Busy});
    end
    Ack = 1'b0; step();
    $display("test_timeout done");
  endtask

  task automatic test_saturate();
    logic [1:0] exp_p;
    exp_p = TALLY_ON ? 2'd3 : 2'd0;
    for (int i = 0; i < 5; i++) do_pass_run();
    vectors++;
    if ({Pass, pass_count} !== {1'b1, exp_p}) begin
      miscompares++;
      $display("FAIL saturate got={Pass,pass_count}=%b want=%b", {Pass, pass_count}, {1'b1, exp_p});
    end
    Start = 1'b1; Ack = 1'b1; step();
    vectors++;
    if ({Run, Busy, Pass} !== 3'b110) begin
      miscompares++;
      $display("FAIL start_beats_ack got={Run,Busy,Pass}=%b want=110", {Run, Busy, Pass});
    end
    Start = 1'b0; Ack = 1'b0;
    $display("test_saturate done pass_count=%0d", pass_count);
  endtask

  task automatic test_reset_mid_wait();
    step();
    vectors++;
    if (Busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_wait_busy got=%b want=1", Busy);
    end
    Reset_n = 1'b0; step();
    vectors++;
    if ({Run, DISP_RSLT, Busy, Pass, Fail, Timeout, pass_count, fail_count} !== 10'b0) begin
      miscompares++;
      $display("FAIL mid_wait_reset got=%b want=0000000000",
               {Run, DISP_RSLT, Busy, Pass, Fail, Timeout, pass_count, fail_count});
    end
    Reset_n = 1'b1; step(); step();
    vectors++;
    if ({Run, Busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle got={Run,Busy}=%b want=00", {Run, Busy});
    end
    $display("test_reset_mid_wait done");
  endtask

  initial begin
    test_reset();
    test_pass();
    test_fail_ack();
    test_timeout();
    test_saturate();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/chip_test_sequencer.md
# chip_test_sequencer

Sequences one chip-tester run from user controls and consumes the tester's `Done`/`RSLT` outputs.
- Turns a debounced Start button into a single-cycle `Run` pulse and waits for `Done`, with a timeout.
- Captures the pass/fail result, releases the tester via `DISP_RSLT`, and holds the verdict for the display logic until acknowledged.
- Sits between the board button/switch logic and the per-chip tester modules (7400/7404/...).

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 50000: maximum cycles in WAIT before declaring timeout; legal range 2 to 2^16-1.
- `CNT_W`, default 8: width of the pass/fail tally counters.

Ports (one clock; reset is synchronous and active-low):
- `Clk` in 1: system clock; all state updates on rising edge.
- `Reset_n` in 1: synchronous, active-low reset.
- `Start` in 1: debounced user run request (level); its rising edge launches a test.
- `Ack` in 1: debounced user acknowledge (level); its rising edge clears the verdict.
- `Done` in 1: from the chip tester.
- `RSLT` in 1: from the chip tester, registered pass flag.
- `Run` out 1: to the chip tester; one-cycle launch pulse.
- `DISP_RSLT` out 1: to the chip tester; one-cycle release pulse.
- `Busy` out 1: high in LAUNCH, WAIT and CAPTURE.
- `Pass` out 1: verdict, chip passed.
- `Fail` out 1: verdict, chip failed.
- `Timeout` out 1: tester never asserted `Done`.
- `pass_count` out CNT_W: saturating count of passes since reset.
- `fail_count` out CNT_W: saturating count of fails since reset.

## Operation
Edge detection:
- `Start_q` and `Ack_q` are registered copies of the inputs, reset to 1.
- `start_edge = Start & ~Start_q`; `ack_edge = Ack & ~Ack_q`.
- A button held through reset therefore does not launch or acknowledge.

State machine (states: IDLE, LAUNCH, WAIT, CAPTURE, SHOW, FAULT):
- **IDLE:** `start_edge` → LAUNCH. `ack_edge` is ignored.
- **LAUNCH:** `Run`=1 for exactly this cycle. `Pass`/`Fail`/`Timeout` are cleared and the timeout counter is zeroed. Always → WAIT.
- **WAIT:** the timeout counter increments each cycle.
  - `Done`=1 → CAPTURE. `Done` has priority over timeout in the same cycle.
  - Else, counter == TIMEOUT_CYCLES-1 → FAULT.
  - `Start`/`Ack` edges are ignored.
- **CAPTURE:** the tester's `RSLT` is valid one cycle after `Done` first rises, so it is sampled here, not in WAIT.
  - `RSLT`=1 → set `Pass`, increment `pass_count`.
  - `RSLT`=0 → set `Fail`, increment `fail_count`.
  - `DISP_RSLT`=1 for this cycle only. Always → SHOW.
- **SHOW:** the verdict is held.
  - `start_edge` → LAUNCH (immediate retest; verdict cleared there).
  - Else `ack_edge` → IDLE, clearing `Pass`/`Fail`.
- **FAULT:** `Timeout`=1, held. `DISP_RSLT`=1 on the entry cycle only. `ack_edge` → IDLE, clearing `Timeout`. `start_edge` → LAUNCH.

Rules and boundary conditions:
- `Pass`, `Fail` and `Timeout` are mutually exclusive; at most one is high.
- Tallies saturate at 2^CNT_W-1 and do not wrap. They are unaffected by timeouts.
- Simultaneous `start_edge` and `ack_edge` in SHOW or FAULT: Start wins.

## Timing
- Reset (`Reset_n`=0 at a rising edge), including mid-test: state=IDLE.
  - All outputs 0: `Run`, `DISP_RSLT`, `Busy`, `Pass`, `Fail`, `Timeout`, both counts.
  - `Start_q`=`Ack_q`=1; timeout counter 0.
- `Start` rises before edge k → LAUNCH during cycle k+1 (`Run`=1) → WAIT from cycle k+2.
- `Done` first high in WAIT cycle m → CAPTURE in m+1 (`RSLT` sampled, `DISP_RSLT`=1) → SHOW in m+2 with the verdict and count visible.
- Timeout: FAULT is entered exactly TIMEOUT_CYCLES cycles after WAIT entry if `Done` stays low.
- All outputs are registered or decoded from the registered state only; no input-to-output combinational path.

## Configuration
- `SEQ_TALLY_EN` defined: `pass_count`/`fail_count` registers and saturating increment logic are compiled in.
- `SEQ_TALLY_EN` undefined: both counts are tied to 0 and no counter registers exist. Everything else is unchanged.

## Structure
- Shared package `chip_test_pkg` holds:
  - `seq_state_t` enum (IDLE, LAUNCH, WAIT, CAPTURE, SHOW, FAULT).
  - `verdict_t` enum (NONE, PASS, FAIL, TIMEOUT).
  - Default timeout constant `SEQ_TIMEOUT_DEFAULT`.
- One sub-module, `rise_edge_detect`: a register with reset value 1 plus the AND-NOT, instantiated twice (Start, Ack).

## Test plan
- Hold `Start`=1 through and after reset → `Run` never pulses; all outputs 0; counts 0.
- Start edge; tester model raises `Done` 3 cycles after `Run` with `RSLT`=1 → one-cycle `Run`, one-cycle `DISP_RSLT` in CAPTURE, `Pass`=1, `pass_count`=1, `Busy`=0 in SHOW.
- Same run with `RSLT`=0, then `Ack` edge → `Fail`=1 and `fail_count`=1; after `Ack`, IDLE with `Fail`=0.
- `TIMEOUT_CYCLES`=8, `Done` held 0 → `Timeout`=1 exactly 8 cycles after WAIT entry; counts unchanged; `Ack` → IDLE.
- `CNT_W`=2: five passes, then `Start` and `Ack` edges in the same cycle while in SHOW → `pass_count`=3 (saturated); relaunch taken with `Pass` cleared in LAUNCH.
- `Reset_n`=0 for one edge during WAIT → next cycle IDLE, all outputs and counts 0.
